lsr_share_seq: RTL
==================

# lsr_share_seq

Sequencer and two-port round-robin arbiter for the 4-bit logical-shift-right barrel shifter (amount 0..WIDTH-1 per pass). It gives two requesters shared access to one shifter instance. It also extends the reach to arbitrary shift amounts by iterating the shifter over multiple clocked passes. The block sits between client logic and the LSR datapath and returns tagged results over a valid/ready response port.

## Interface
- WIDTH, 4: data width of the shared shifter; power of two, ≥2; max shift per pass = WIDTH-1
- AMT_WIDTH, 4: width of the requested shift amount
- CLK  in  1  clock; all state updates on rising edge
- ASYNCRESETN  in  1  reset, asynchronous assert, active-low
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle when also valid
- req0_data  in  WIDTH  operand from requester 0
- req0_amt  in  AMT_WIDTH  shift amount from requester 0
- req1_valid / req1_ready / req1_data / req1_amt: same as above, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  WIDTH  operand >> amount (zero fill)
- resp_id  out  1  index of the requester that owns the result

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE, priority pointer = 0, data/remaining/id registers = 0.
- IDLE arbitration:
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester named by the pointer is granted.
  - req_ready is asserted only for the granted requester, and only in IDLE.
  - Ready may depend combinationally on both valids. Valid must never depend on ready.
- Accept (valid & ready at edge):
  - D ← data, R ← amt, id ← granted index.
  - Pointer ← the other index (the winner loses priority next time).
  - State → SHIFT.
- SHIFT, each edge:
  - s = min(R, WIDTH-1); D ← D >> s through the shared shifter; R ← R - s.
  - If R ≤ WIDTH-1 before the update, state → DONE. Otherwise stay in SHIFT.
  - Amount 0 still takes exactly one pass, shifting by 0.
- DONE:
  - resp_valid = 1; resp_data = D; resp_id = id.
  - Data and id are held stable until resp_ready. On resp_valid & resp_ready, state → IDLE.
- No early exit when D reaches zero. Any amount ≥ WIDTH gives a zero result.
- No request is accepted while in SHIFT or DONE. There is no accept in the same cycle as the response handshake.
- Reset mid-operation aborts the request: no response is emitted, all outputs go to 0, and the pointer returns to 0.

## Timing
- Passes P = max(1, ceil(amt/(WIDTH-1))). WIDTH=4: amt 0–3 → 1, 4–6 → 2, 7 → 3, 15 → 5.
- Accept edge at cycle T; resp_valid is first high in cycle T+P+1, i.e. after P SHIFT edges.
- Minimum spacing between accepts is P+2 cycles when resp_ready is held high.
- Outputs while in reset and immediately after reset:
  - req0_ready = req1_ready = 0 while ASYNCRESETN = 0.
  - resp_valid = 0; resp_data = 0; resp_id = 0.
- resp_valid, resp_data and resp_id are driven from registers. No combinational path from inputs to the response outputs.
- Back-pressure: if resp_ready is held low, the block stays in DONE indefinitely, with the response and both req_ready held stable at their DONE values.

## Test plan
- Single request: req0 data=4'b1011, amt=1 → accepted in IDLE; resp_valid 2 cycles later with data 4'b0101, id 0.
- Multi-pass: req1 data=4'b1111, amt=5 → 2 passes; resp data 4'b0000, id 1, resp_valid at T+3. Also data=4'b1000, amt=2 → 4'b0010 after 1 pass.
- Contention fairness:
  - Both requesters valid continuously after reset: grants alternate 0,1,0,1.
  - resp_id sequence matches the grants.
  - The non-granted ready stays 0 throughout.
- Back-pressure: hold resp_ready low for 5 cycles in DONE → resp_data/resp_id stable, no new accept. Raise resp_ready → IDLE next edge, and a pending request is accepted the cycle after.
- Amount 0 and maximum: amt=0, data=4'b0110 → 4'b0110 after 1 pass. amt=15 → 0 after exactly 5 passes.
- Reset mid-SHIFT: assert ASYNCRESETN low during pass 2 of an amt=7 request → outputs 0 immediately, no response after release, next contended grant goes to requester 0.

Source files
------------

// File: rtl/lsr_share_seq.sv
// rtl/lsr_share_seq.sv - two-port round-robin front end that iterates one LSR shifter over multi-pass shifts
module lsr_share_seq #(
  parameter int WIDTH     = 4,
  parameter int AMT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_data,
  input  logic [AMT_WIDTH-1:0] req0_amt,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_data,
  input  logic [AMT_WIDTH-1:0] req1_amt,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic                 resp_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [AMT_WIDTH-1:0] MAX_STEP = AMT_WIDTH'(WIDTH - 1);

  logic [1:0]           state;
  logic                 ptr;
  logic [WIDTH-1:0]     data_q;
  logic [AMT_WIDTH-1:0] rem_q;
  logic                 id_q;

  logic                 grant;
  logic                 take;
  logic                 accept;
  logic [AMT_WIDTH-1:0] step;
  logic [WIDTH-1:0]     shifted;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant      = (req0_valid & req1_valid) ? ptr : req1_valid;
    take       = (state == IDLE) & ASYNCRESETN;
    req0_ready = take & req0_valid & ~grant;
    req1_ready = take & req1_valid & grant;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // The single shared shifter: one pass moves at most WIDTH-1 positions.
  always_comb begin
    step    = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;
    shifted = data_q >> step;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      data_q <= '0;
      rem_q  <= '0;
      id_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= grant ? req1_data : req0_data;
            rem_q  <= grant ? req1_amt : req0_amt;
            id_q   <= grant;
            ptr    <= ~grant;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= shifted;
          rem_q  <= rem_q - step;
          if (rem_q <= MAX_STEP) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_data  = data_q;
  assign resp_id    = id_q;

endmodule
